// File: rtl/coin_casher_multi_if.sv
// Coin casher signal bundle: coin mech / hopper / game controller side of the block.
// master drives the requests (mech, buttons, game controller); slave is the casher.
interface coin_casher_multi_if #(
   parameter int unsigned CREDIT_W = 11
);
   logic                coin_insert;
   logic [2:0]          inserted_coin;
   logic                return_coin;
   logic                game_finish;
   logic                coin_reject;
   logic                eat_coins;
   logic                game_start;
   logic                wait_ready;
   logic                in_game;
   logic                spit_coin;
   logic [2:0]          spit_value;
   logic [CREDIT_W-1:0] credit;
   logic                timer_active;

   modport master (
      output coin_insert, inserted_coin, return_coin, game_finish,
      input  coin_reject, eat_coins, game_start, wait_ready, in_game,
             spit_coin, spit_value, credit, timer_active
   );

   modport slave (
      input  coin_insert, inserted_coin, return_coin, game_finish,
      output coin_reject, eat_coins, game_start, wait_ready, in_game,
             spit_coin, spit_value, credit, timer_active
   );
endinterface

// File: rtl/coin_casher_multi.sv
// Coin acceptor / credit controller. Validates coin codes against ACCEPT_MASK, accumulates
// credit toward PRICE_CENTS, starts games, and refunds greedily (100/25/10/5) on request
// or inactivity timeout.
// Optional feature macro: COIN_CASHER_CHANGE_EN -- pay back overpayment residual right
// after a game start instead of carrying it to the next game.
module coin_casher_multi #(
   parameter int unsigned PRICE_CENTS    = 300,
   parameter int unsigned MAX_CREDIT     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]  ACCEPT_MASK    = 8'h18,
   parameter int unsigned CREDIT_W       = 11
) (
   input logic                clk,
   input logic                power_n,
   coin_casher_multi_if.slave bus
);

   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SumW   = CREDIT_W + 1;

   typedef enum logic [2:0] {
      StIdle, StCheck, StReject, StAccum, StStart, StChange, StPlay, StRefund
   } state_e;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic                timer_run_q, timer_run_d;
   logic [2:0]          coin_q, coin_d;

   // Cents value of a coin code; invalid codes are worth nothing.
   function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] code);
      unique case (code)
         3'd1:    coin_value = CREDIT_W'(5);
         3'd2:    coin_value = CREDIT_W'(10);
         3'd3:    coin_value = CREDIT_W'(25);
         3'd4:    coin_value = CREDIT_W'(100);
         default: coin_value = '0;
      endcase
   endfunction

   // Largest dispensable coin not exceeding the given credit (0 if none fits).
   function automatic logic [2:0] pick_code(input logic [CREDIT_W-1:0] amount);
      if (amount >= CREDIT_W'(100))     pick_code = 3'd4;
      else if (amount >= CREDIT_W'(25)) pick_code = 3'd3;
      else if (amount >= CREDIT_W'(10)) pick_code = 3'd2;
      else if (amount >= CREDIT_W'(5))  pick_code = 3'd1;
      else                              pick_code = 3'd0;
   endfunction

   logic [SumW-1:0]     credit_sum;
   logic                coin_ok;
   logic                credit_nz;
   logic                expire;
   logic [2:0]          pay_code;
   logic [CREDIT_W-1:0] pay_left;
   logic [CREDIT_W-1:0] residual;

   // Shared datapath terms: coin validation, expiry, greedy dispense and price residual.
   always_comb begin
      credit_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_q)};
      coin_ok    = (coin_q inside {3'd1, 3'd2, 3'd3, 3'd4}) && ACCEPT_MASK[coin_q] &&
                   (credit_sum <= SumW'(MAX_CREDIT));
      credit_nz  = (credit_q != '0);
      // Expiry fires on the IDLE cycle whose decrement reaches zero.
      expire     = timer_run_q && credit_nz && (timer_q <= TimerW'(1));
      pay_code   = pick_code(credit_q);
      // A sub-5c remainder cannot be paid out; it is dropped rather than looping forever.
      pay_left   = (pay_code == 3'd0) ? '0 : credit_q - coin_value(pay_code);
      residual   = credit_q - CREDIT_W'(PRICE_CENTS);
   end

   logic coin_reject, eat_coins, game_start, wait_ready, in_game, spit_coin;
   logic [2:0] spit_value;

   // Next-state, credit/timer update and Moore-style outputs.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      timer_d     = timer_q;
      timer_run_d = timer_run_q;
      coin_d      = coin_q;
      coin_reject = 1'b0;
      eat_coins   = 1'b0;
      game_start  = 1'b0;
      wait_ready  = 1'b0;
      in_game     = 1'b0;
      spit_coin   = 1'b0;
      spit_value  = 3'd0;

      unique case (state_q)
         StIdle: begin
            wait_ready = 1'b1;
            if (timer_run_q && (timer_q != '0)) timer_d = timer_q - TimerW'(1);
            if (bus.return_coin) begin
               // Refund wins over a simultaneous coin; that coin is rejected in REFUND.
               if (credit_nz) begin
                  state_d     = StRefund;
                  timer_d     = '0;
                  timer_run_d = 1'b0;
               end
            end else if (bus.coin_insert) begin
               coin_d  = bus.inserted_coin;
               state_d = StCheck;
            end else if (expire) begin
               state_d     = StRefund;
               timer_d     = '0;
               timer_run_d = 1'b0;
            end
         end
         StCheck: begin
            if (coin_ok) begin
               credit_d = credit_sum[CREDIT_W-1:0];
               state_d  = StAccum;
            end else begin
               state_d = StReject;
            end
         end
         StReject: begin
            coin_reject = 1'b1;
            state_d     = StIdle;
         end
         StAccum: begin
            if (credit_q >= CREDIT_W'(PRICE_CENTS)) begin
               state_d = StStart;
            end else begin
               timer_d     = TimerW'(TIMEOUT_CYCLES);
               timer_run_d = 1'b1;
               state_d     = StIdle;
            end
         end
         StStart: begin
            coin_reject = 1'b1;
            eat_coins   = 1'b1;
            game_start  = 1'b1;
            credit_d    = residual;
            timer_d     = '0;
            timer_run_d = 1'b0;
`ifdef COIN_CASHER_CHANGE_EN
            state_d = (residual != '0) ? StChange : StPlay;
`else
            state_d = StPlay;
`endif
         end
         StChange, StRefund: begin
            coin_reject = 1'b1;
            spit_coin   = (pay_code != 3'd0);
            spit_value  = pay_code;
            credit_d    = pay_left;
            if (pay_left == '0) state_d = (state_q == StChange) ? StPlay : StIdle;
         end
         StPlay: begin
            coin_reject = 1'b1;
            in_game     = 1'b1;
            if (bus.game_finish) begin
               state_d     = StIdle;
               timer_d     = credit_nz ? TimerW'(TIMEOUT_CYCLES) : '0;
               timer_run_d = credit_nz;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; power loss discards credit without refunding.
   always_ff @(posedge clk or negedge power_n) begin
      if (!power_n) begin
         state_q     <= StIdle;
         credit_q    <= '0;
         timer_q     <= '0;
         timer_run_q <= 1'b0;
         coin_q      <= 3'd0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         timer_q     <= timer_d;
         timer_run_q <= timer_run_d;
         coin_q      <= coin_d;
      end
   end

   assign bus.coin_reject  = coin_reject;
   assign bus.eat_coins    = eat_coins;
   assign bus.game_start   = game_start;
   assign bus.wait_ready   = wait_ready;
   assign bus.in_game      = in_game;
   assign bus.spit_coin    = spit_coin;
   assign bus.spit_value   = spit_value;
   assign bus.credit       = credit_q;
   assign bus.timer_active = timer_run_q && credit_nz;

endmodule

// File: tb/tb_coin_casher_multi.sv
// Directed bench for coin_casher_multi (PRICE 300, TIMEOUT 20, default mask/ceiling).
// Expectations follow COIN_CASHER_CHANGE_EN when it is defined for the build.
module tb_coin_casher_multi;
   localparam int unsigned CW = 11;

   logic clk = 1'b0;
   logic power_n;
   int   checks   = 0;
   int   failures = 0;

   coin_casher_multi_if #(.CREDIT_W(CW)) bus ();

   coin_casher_multi #(
      .PRICE_CENTS   (300),
      .MAX_CREDIT    (1000),
      .TIMEOUT_CYCLES(20),
      .ACCEPT_MASK   (8'h18),
      .CREDIT_W      (CW)
   ) dut (
      .clk    (clk),
      .power_n(power_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe a coin for one cycle; returns with the DUT in CHECK.
   task automatic insert(input logic [2:0] code);
      bus.coin_insert   = 1'b1;
      bus.inserted_coin = code;
      tick();
      bus.coin_insert   = 1'b0;
      bus.inserted_coin = 3'd0;
   endtask

   task automatic test_reset();
      int spits;
      power_n = 1'b0;
      bus.coin_insert = 1'b0; bus.inserted_coin = 3'd0;
      bus.return_coin = 1'b0; bus.game_finish = 1'b0;
      tick(); tick();
      checks++; if (bus.wait_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_ready got %b want 1", bus.wait_ready); end
      checks++; if (bus.credit !== 11'd0) begin failures++; $display("FAIL rst_credit got %0d want 0", bus.credit); end
      checks++; if ({bus.coin_reject, bus.eat_coins, bus.game_start, bus.in_game, bus.spit_coin, bus.timer_active} !== 6'b0)
         begin failures++; $display("FAIL rst_outputs got %b want 000000", {bus.coin_reject, bus.eat_coins, bus.game_start, bus.in_game, bus.spit_coin, bus.timer_active}); end
      power_n = 1'b1;
      tick();
      insert(3'd4); tick(); tick();
      insert(3'd4); tick();   // now in ACCUM holding 200
      checks++; if (bus.credit !== 11'd200) begin failures++; $display("FAIL rst_pre_credit got %0d want 200", bus.credit); end
      power_n = 1'b0;
      #1;
      checks++; if (bus.credit !== 11'd0) begin failures++; $display("FAIL rst_mid_credit got %0d want 0", bus.credit); end
      checks++; if (bus.wait_ready !== 1'b1 || bus.spit_coin !== 1'b0 || bus.timer_active !== 1'b0)
         begin failures++; $display("FAIL rst_mid_outputs got wr=%b spit=%b ta=%b want 1 0 0", bus.wait_ready, bus.spit_coin, bus.timer_active); end
      #2;
      power_n = 1'b1;
      spits = 0;
      repeat (30) begin tick(); if (bus.spit_coin === 1'b1) spits++; end
      checks++; if (spits != 0 || bus.credit !== 11'd0) begin failures++; $display("FAIL rst_no_refund got spits=%0d credit=%0d want 0 0", spits, bus.credit); end
   endtask

   task automatic test_reject_5c();
      insert(3'd1);
      tick();   // T2: REJECT
      checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 11'd0)
         begin failures++; $display("FAIL rej5_t2 got reject=%b credit=%0d want 1 0", bus.coin_reject, bus.credit); end
      tick();
      checks++; if (bus.coin_reject !== 1'b0 || bus.wait_ready !== 1'b1 || bus.credit !== 11'd0)
         begin failures++; $display("FAIL rej5_t3 got reject=%b wr=%b credit=%0d want 0 1 0", bus.coin_reject, bus.wait_ready, bus.credit); end
   endtask

   task automatic test_invalid_codes();
      logic [2:0] codes [4];
      codes = '{3'd0, 3'd2, 3'd5, 3'd7};
      for (int i = 0; i < 4; i++) begin
         insert(codes[i]);
         tick();
         checks++; if (bus.coin_reject !== 1'b1) begin failures++; $display("FAIL rej_code%0d got reject=%b want 1", codes[i], bus.coin_reject); end
         tick();
         checks++; if (bus.credit !== 11'd0) begin failures++; $display("FAIL rej_code%0d_credit got %0d want 0", codes[i], bus.credit); end
      end
   endtask

   task automatic test_single_game();
      insert(3'd4); tick();
      checks++; if (bus.credit !== 11'd100) begin failures++; $display("FAIL game_c1 got %0d want 100", bus.credit); end
      tick();
      insert(3'd4); tick();
      checks++; if (bus.credit !== 11'd200) begin failures++; $display("FAIL game_c2 got %0d want 200", bus.credit); end
      tick();
      insert(3'd4); tick();
      checks++; if (bus.credit !== 11'd300) begin failures++; $display("FAIL game_c3 got %0d want 300", bus.credit); end
      tick();   // START
      checks++; if (bus.game_start !== 1'b1 || bus.eat_coins !== 1'b1)
         begin failures++; $display("FAIL game_start got gs=%b eat=%b want 1 1", bus.game_start, bus.eat_coins); end
      tick();   // PLAY
      checks++; if (bus.in_game !== 1'b1 || bus.game_start !== 1'b0 || bus.credit !== 11'd0)
         begin failures++; $display("FAIL game_play got ig=%b gs=%b credit=%0d want 1 0 0", bus.in_game, bus.game_start, bus.credit); end
      bus.coin_insert = 1'b1; bus.inserted_coin = 3'd4; bus.return_coin = 1'b1;
      tick();
      bus.coin_insert = 1'b0; bus.inserted_coin = 3'd0; bus.return_coin = 1'b0;
      tick();
      checks++; if (bus.in_game !== 1'b1 || bus.coin_reject !== 1'b1 || bus.credit !== 11'd0 || bus.spit_coin !== 1'b0)
         begin failures++; $display("FAIL game_ignore got ig=%b rej=%b credit=%0d spit=%b want 1 1 0 0", bus.in_game, bus.coin_reject, bus.credit, bus.spit_coin); end
      bus.game_finish = 1'b1;
      tick();
      bus.game_finish = 1'b0;
      checks++; if (bus.wait_ready !== 1'b1 || bus.timer_active !== 1'b0 || bus.in_game !== 1'b0)
         begin failures++; $display("FAIL game_end got wr=%b ta=%b ig=%b want 1 0 0", bus.wait_ready, bus.timer_active, bus.in_game); end
   endtask

   task automatic test_change();
      logic [CW-1:0] exp_left;
      logic          exp_ta;
`ifdef COIN_CASHER_CHANGE_EN
      exp_left = 11'd0;  exp_ta = 1'b0;
`else
      exp_left = 11'd25; exp_ta = 1'b1;
`endif
      insert(3'd4); tick(); tick();
      insert(3'd4); tick(); tick();
      insert(3'd3); tick(); tick();
      checks++; if (bus.credit !== 11'd225) begin failures++; $display("FAIL chg_225 got %0d want 225", bus.credit); end
      insert(3'd4); tick();
      checks++; if (bus.credit !== 11'd325) begin failures++; $display("FAIL chg_325 got %0d want 325", bus.credit); end
      tick();   // START
      checks++; if (bus.game_start !== 1'b1 || bus.eat_coins !== 1'b1)
         begin failures++; $display("FAIL chg_start got gs=%b eat=%b want 1 1", bus.game_start, bus.eat_coins); end
      tick();
`ifdef COIN_CASHER_CHANGE_EN
      checks++; if (bus.spit_coin !== 1'b1 || bus.spit_value !== 3'd3 || bus.coin_reject !== 1'b1)
         begin failures++; $display("FAIL chg_spit got spit=%b val=%0d rej=%b want 1 3 1", bus.spit_coin, bus.spit_value, bus.coin_reject); end
      tick();
`endif
      checks++; if (bus.in_game !== 1'b1 || bus.credit !== exp_left || bus.spit_coin !== 1'b0 || bus.spit_value !== 3'd0)
         begin failures++; $display("FAIL chg_play got ig=%b credit=%0d spit=%b val=%0d want 1 %0d 0 0", bus.in_game, bus.credit, bus.spit_coin, bus.spit_value, exp_left); end
      bus.game_finish = 1'b1;
      tick();
      bus.game_finish = 1'b0;
      checks++; if (bus.wait_ready !== 1'b1 || bus.credit !== exp_left || bus.timer_active !== exp_ta)
         begin failures++; $display("FAIL chg_idle got wr=%b credit=%0d ta=%b want 1 %0d %b", bus.wait_ready, bus.credit, bus.timer_active, exp_left, exp_ta); end
`ifndef COIN_CASHER_CHANGE_EN
      bus.return_coin = 1'b1;
      tick();
      bus.return_coin = 1'b0;
      checks++; if (bus.spit_coin !== 1'b1 || bus.spit_value !== 3'd3)
         begin failures++; $display("FAIL chg_carry_refund got spit=%b val=%0d want 1 3", bus.spit_coin, bus.spit_value); end
      tick();
      checks++; if (bus.credit !== 11'd0 || bus.wait_ready !== 1'b1)
         begin failures++; $display("FAIL chg_carry_done got credit=%0d wr=%b want 0 1", bus.credit, bus.wait_ready); end
`endif
   endtask

   task automatic test_timeout();
      int n;
      insert(3'd4); tick(); tick();
      insert(3'd3); tick(); tick();
      checks++; if (bus.credit !== 11'd125 || bus.timer_active !== 1'b1)
         begin failures++; $display("FAIL to_armed got credit=%0d ta=%b want 125 1", bus.credit, bus.timer_active); end
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (bus.spit_coin === 1'b1) break;
      end
      checks++; if (n != 20) begin failures++; $display("FAIL to_delay got %0d cycles want 20", n); end
      checks++; if (bus.spit_coin !== 1'b1 || bus.spit_value !== 3'd4 || bus.timer_active !== 1'b0)
         begin failures++; $display("FAIL to_spit1 got spit=%b val=%0d ta=%b want 1 4 0", bus.spit_coin, bus.spit_value, bus.timer_active); end
      tick();
      checks++; if (bus.spit_coin !== 1'b1 || bus.spit_value !== 3'd3)
         begin failures++; $display("FAIL to_spit2 got spit=%b val=%0d want 1 3", bus.spit_coin, bus.spit_value); end
      tick();
      checks++; if (bus.spit_coin !== 1'b0 || bus.credit !== 11'd0 || bus.wait_ready !== 1'b1)
         begin failures++; $display("FAIL to_done got spit=%b credit=%0d wr=%b want 0 0 1", bus.spit_coin, bus.credit, bus.wait_ready); end
   endtask

   task automatic test_back_to_back_refund();
      int spits;
      insert(3'd4); tick(); tick();
      checks++; if (bus.credit !== 11'd100) begin failures++; $display("FAIL sim_pre got %0d want 100", bus.credit); end
      bus.return_coin = 1'b1; bus.coin_insert = 1'b1; bus.inserted_coin = 3'd4;
      tick();
      bus.return_coin = 1'b0; bus.coin_insert = 1'b0; bus.inserted_coin = 3'd0;
      checks++; if (bus.coin_reject !== 1'b1 || bus.spit_coin !== 1'b1 || bus.spit_value !== 3'd4 || bus.credit !== 11'd100)
         begin failures++; $display("FAIL sim_refund got rej=%b spit=%b val=%0d credit=%0d want 1 1 4 100", bus.coin_reject, bus.spit_coin, bus.spit_value, bus.credit); end
      spits = 1;
      repeat (6) begin tick(); if (bus.spit_coin === 1'b1) spits++; end
      checks++; if (spits != 1 || bus.credit !== 11'd0 || bus.wait_ready !== 1'b1)
         begin failures++; $display("FAIL sim_single got spits=%0d credit=%0d wr=%b want 1 0 1", spits, bus.credit, bus.wait_ready); end
   endtask

   initial begin
      test_reset();
      test_reject_5c();
      test_invalid_codes();
      test_single_game();
      test_change();
      test_timeout();
      test_back_to_back_refund();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
